// File: rtl/debug_pkg.sv
// Shared types and defaults for the front-panel debug memory writer.
// Holds the FSM encoding, default timing constants and address helper.
package debug_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ_LO = 3'd1,
        ST_GAP    = 3'd2,
        ST_REQ_HI = 3'd3,
        ST_ABORT  = 3'd4
    } state_e;

    localparam logic [15:0] DEF_DEBOUNCE_CYCLES = 16'd50000;
    localparam logic [7:0]  DEF_ACK_TIMEOUT     = 8'd255;

    // 16-bit wrap-around address step
    function automatic logic [15:0] addr_add(
        input logic [15:0] a,
        input logic [1:0]  n
    );
        return a + {14'd0, n};
    endfunction

endpackage

// File: rtl/debug_mem_writer_key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, level debouncer and
// a one-cycle press pulse on the debounced release-to-pressed edge.
module key_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = debug_pkg::DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic press_o
);

    localparam logic [15:0] LIMIT =
        (DEBOUNCE_CYCLES == 16'd0) ? 16'd0 : DEBOUNCE_CYCLES - 16'd1;

    logic        sync1_q;
    logic        sync2_q;
    logic        level_q;
    logic        level_d;
    logic        press_q;
    logic        press_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // counter only runs while the input disagrees with the accepted level
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q >= LIMIT) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/debug_mem_writer.sv
// Front-panel memory writer: loads an address from switches and writes
// one byte or a little-endian word through a req/ack memory port.
module debug_mem_writer #(
    parameter logic [15:0] DEBOUNCE_CYCLES = debug_pkg::DEF_DEBOUNCE_CYCLES,
    parameter logic [7:0]  ACK_TIMEOUT     = debug_pkg::DEF_ACK_TIMEOUT
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] SW,
    input  logic        key_addr_n,
    input  logic        key_data_n,
    input  logic        word_mode,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    output logic [15:0] cur_addr,
    output logic        busy,
    output logic        err,
    output logic [7:0]  wr_count
);

    import debug_pkg::*;

    localparam logic [7:0] TO_LIMIT =
        (ACK_TIMEOUT == 8'd0) ? 8'd0 : ACK_TIMEOUT - 8'd1;

    logic addr_press;
    logic data_press;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_addr (
        .clk_i  (Clock),
        .rst_i  (Reset),
        .key_n_i(key_addr_n),
        .press_o(addr_press)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_data (
        .clk_i  (Clock),
        .rst_i  (Reset),
        .key_n_i(key_data_n),
        .press_o(data_press)
    );

    state_e      state_q;
    state_e      state_d;
    logic [15:0] cur_q;
    logic [15:0] cur_d;
    logic [15:0] data_q;
    logic [15:0] data_d;
    logic        word_q;
    logic        word_d;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic        err_q;
    logic        err_d;
    logic [7:0]  to_q;
    logic [7:0]  to_d;
    logic        timeout_hit;

    assign timeout_hit = (to_q >= TO_LIMIT);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!addr_press && data_press) begin
                    state_d = ST_REQ_LO;
                end
            end
            ST_REQ_LO: begin
                if (mem_ack) begin
                    state_d = word_q ? ST_GAP : ST_IDLE;
                end else if (timeout_hit) begin
                    state_d = ST_ABORT;
                end
            end
            ST_GAP: state_d = ST_REQ_HI;
            ST_REQ_HI: begin
                if (mem_ack) begin
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = (state_q != ST_IDLE);
        unique case (state_q)
            ST_REQ_LO: begin
                mem_req   = 1'b1;
                mem_addr  = cur_q;
                mem_wdata = data_q[7:0];
            end
            ST_REQ_HI: begin
                mem_req   = 1'b1;
                mem_addr  = addr_add(cur_q, 2'd1);
                mem_wdata = data_q[15:8];
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cur_q  <= '0;
            data_q <= '0;
            word_q <= 1'b0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            to_q   <= '0;
        end else begin
            cur_q  <= cur_d;
            data_q <= data_d;
            word_q <= word_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            to_q   <= to_d;
        end
    end

    // cur_addr only advances once the whole byte/word has been accepted
    always_comb begin
        cur_d  = cur_q;
        data_d = data_q;
        word_d = word_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        to_d   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (addr_press) begin
                    cur_d = SW;
                    err_d = 1'b0;
                end else if (data_press) begin
                    data_d = SW;
                    word_d = word_mode;
                end
            end
            ST_REQ_LO: begin
                if (mem_ack) begin
                    cnt_d = cnt_q + 8'd1;
                    if (!word_q) begin
                        cur_d = addr_add(cur_q, 2'd1);
                    end
                end else if (timeout_hit) begin
                    err_d = 1'b1;
                end else begin
                    to_d = to_q + 8'd1;
                end
            end
            ST_REQ_HI: begin
                if (mem_ack) begin
                    cnt_d = cnt_q + 8'd1;
                    cur_d = addr_add(cur_q, 2'd2);
                end else if (timeout_hit) begin
                    err_d = 1'b1;
                end else begin
                    to_d = to_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign cur_addr = cur_q;
    assign err      = err_q;
    assign wr_count = cnt_q;

endmodule

// File: tb/tb_debug_mem_writer.sv
// Scoreboard bench for debug_mem_writer: directed corner cases plus
// randomized key/ack traffic against a write-list reference model.
module tb_debug_mem_writer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] SW;
    logic        key_addr_n;
    logic        key_data_n;
    logic        word_mode;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [15:0] cur_addr;
    logic        busy;
    logic        err;
    logic [7:0]  wr_count;

    always #5 Clock = ~Clock;

    debug_mem_writer #(
        .DEBOUNCE_CYCLES(16'd4),
        .ACK_TIMEOUT    (8'd8)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .SW        (SW),
        .key_addr_n(key_addr_n),
        .key_data_n(key_data_n),
        .word_mode (word_mode),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .cur_addr  (cur_addr),
        .busy      (busy),
        .err       (err),
        .wr_count  (wr_count)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        bit          lo_of_word;
    } wr_t;

    wr_t         exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] mcur;
    logic [7:0]  mcnt;
    bit          merr;
    bit          ack_en = 1'b0;
    bit          rand_dly = 1'b0;
    int          force_cnt = 0;
    int          n;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic expect_write(input logic [15:0] sw, input bit wm);
        wr_t e;
        e.addr = mcur;
        e.data = sw[7:0];
        e.lo_of_word = wm;
        exp_q.push_back(e);
        if (wm) begin
            e.addr = mcur + 16'd1;
            e.data = sw[15:8];
            e.lo_of_word = 1'b0;
            exp_q.push_back(e);
        end
        mcur = mcur + (wm ? 16'd2 : 16'd1);
        mcnt = mcnt + (wm ? 8'd2 : 8'd1);
    endtask

    task automatic press(input bit a, input bit d,
                         input logic [15:0] sw, input bit wm);
        if (a) begin
            mcur = sw;
            merr = 1'b0;
        end else if (d) begin
            expect_write(sw, wm);
        end
        @(negedge Clock);
        SW = sw;
        word_mode = wm;
        key_addr_n = !a;
        key_data_n = !d;
        repeat (8) @(negedge Clock);
        key_addr_n = 1'b1;
        key_data_n = 1'b1;
        repeat (8) @(negedge Clock);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 100) begin
            @(negedge Clock);
            k++;
        end
        chk("idle_reached", busy, 0);
    endtask

    task automatic wait_req(input string nm);
        int k = 0;
        while (!mem_req && k < 40) begin
            @(negedge Clock);
            k++;
        end
        chk(nm, mem_req, 1);
    endtask

    task automatic check_model(input string nm);
        chk({nm, "_cur_addr"}, cur_addr, mcur);
        chk({nm, "_wr_count"}, wr_count, mcnt);
        chk({nm, "_err"}, err, merr);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_mem_req"}, mem_req, 0);
        chk({nm, "_mem_addr"}, mem_addr, 0);
        chk({nm, "_mem_wdata"}, mem_wdata, 0);
        chk({nm, "_cur_addr"}, cur_addr, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_err"}, err, 0);
        chk({nm, "_wr_count"}, wr_count, 0);
    endtask

    // memory-side responder: drives ack shortly after the active edge
    initial begin
        int wait_c;
        int cur_dly;
        int force_done;
        wait_c = 0;
        cur_dly = 2;
        force_done = 0;
        mem_ack = 1'b0;
        forever begin
            @(posedge Clock);
            #2;
            mem_ack = 1'b0;
            if (force_cnt != force_done) begin
                mem_ack = 1'b1;
                force_done++;
            end else if (ack_en && mem_req) begin
                if (wait_c >= cur_dly) begin
                    mem_ack = 1'b1;
                    wait_c = 0;
                    cur_dly = rand_dly ? int'($urandom_range(0, 3)) : 2;
                end else begin
                    wait_c++;
                end
            end else begin
                wait_c = 0;
            end
        end
    end

    // monitor: every requested byte must match the scoreboard head
    initial begin
        int gap_st;
        wr_t e;
        gap_st = 0;
        forever begin
            @(negedge Clock);
            if (Reset) begin
                gap_st = 0;
            end else begin
                if (gap_st == 1) begin
                    chk("gap_low", mem_req, 0);
                    gap_st = 2;
                end else if (gap_st == 2) begin
                    chk("hi_follows_gap", mem_req, 1);
                    gap_st = 0;
                end else if (gap_st == 3) begin
                    chk("req_drop_after_ack", mem_req, 0);
                    gap_st = 0;
                end
                if (mem_req) begin
                    chk("req_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        chk("mem_addr", mem_addr, exp_q[0].addr);
                        chk("mem_wdata", mem_wdata, exp_q[0].data);
                        if (mem_ack) begin
                            e = exp_q.pop_front();
                            gap_st = e.lo_of_word ? 1 : 3;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sw;
        int r;
        Reset = 1'b1;
        SW = '0;
        key_addr_n = 1'b1;
        key_data_n = 1'b1;
        word_mode = 1'b0;
        mcur = '0;
        mcnt = '0;
        merr = 1'b0;
        repeat (3) @(negedge Clock);
        check_reset_vals("reset");
        Reset = 1'b0;
        ack_en = 1'b1;

        press(1'b1, 1'b0, 16'h1000, 1'b0);
        check_model("addr_load");

        press(1'b0, 1'b1, 16'h00AB, 1'b0);
        wait_idle();
        check_model("byte_write");

        press(1'b1, 1'b0, 16'hFFFF, 1'b0);
        press(1'b0, 1'b1, 16'hBEEF, 1'b1);
        wait_idle();
        check_model("word_wrap");

        expect_write(16'h1234, 1'b0);
        @(negedge Clock);
        SW = 16'h1234;
        word_mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            key_data_n = i[0];
            repeat (2) @(negedge Clock);
        end
        key_data_n = 1'b0;
        repeat (8) @(negedge Clock);
        key_data_n = 1'b1;
        repeat (8) @(negedge Clock);
        wait_idle();
        check_model("bounce");

        press(1'b1, 1'b1, 16'h2222, 1'b1);
        wait_idle();
        check_model("both_keys");

        ack_en = 1'b0;
        begin
            wr_t e;
            e.addr = mcur;
            e.data = 8'h5A;
            e.lo_of_word = 1'b0;
            exp_q.push_back(e);
        end
        @(negedge Clock);
        SW = 16'h775A;
        word_mode = 1'b0;
        key_data_n = 1'b0;
        wait_req("timeout_req_seen");
        key_data_n = 1'b1;
        SW = 16'h5555;
        key_addr_n = 1'b0;
        n = 0;
        while (mem_req && n < 20) begin
            n++;
            @(negedge Clock);
        end
        chk("timeout_len", n, 8);
        chk("abort_err", err, 1);
        chk("abort_busy", busy, 1);
        repeat (8) @(negedge Clock);
        key_addr_n = 1'b1;
        repeat (8) @(negedge Clock);
        wait_idle();
        exp_q.delete();
        merr = 1'b1;
        check_model("timeout");

        press(1'b1, 1'b0, 16'h3000, 1'b0);
        check_model("err_clear");

        expect_write(16'h1122, 1'b1);
        mcur = mcur - 16'd2;
        mcnt = mcnt - 8'd1;
        @(negedge Clock);
        SW = 16'h1122;
        word_mode = 1'b1;
        key_data_n = 1'b0;
        wait_req("hi_to_req_seen");
        force_cnt++;
        key_data_n = 1'b1;
        wait_idle();
        repeat (8) @(negedge Clock);
        exp_q.delete();
        merr = 1'b1;
        check_model("hi_timeout");

        ack_en = 1'b1;
        rand_dly = 1'b1;
        for (int it = 0; it < 40; it++) begin
            r = int'($urandom_range(0, 9));
            sw = 16'($urandom());
            if ($urandom_range(0, 3) == 0) sw = 16'hFFFF;
            if (r < 3) begin
                press(1'b1, 1'b0, sw, 1'b0);
            end else if (r < 9) begin
                press(1'b0, 1'b1, sw, 1'($urandom_range(0, 1)));
            end else begin
                force_cnt++;
                repeat (4) @(negedge Clock);
            end
            wait_idle();
            check_model("rnd");
        end

        ack_en = 1'b0;
        expect_write(16'hCAFE, 1'b1);
        @(negedge Clock);
        SW = 16'hCAFE;
        word_mode = 1'b1;
        key_data_n = 1'b0;
        wait_req("rst_req_seen");
        force_cnt++;
        key_data_n = 1'b1;
        n = 0;
        while (mem_req && n < 10) begin
            @(negedge Clock);
            n++;
        end
        while (!mem_req && n < 20) begin
            @(negedge Clock);
            n++;
        end
        chk("rst_hi_req_seen", mem_req, 1);
        Reset = 1'b1;
        @(negedge Clock);
        check_reset_vals("mid_reset");
        Reset = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge Clock);
        chk("post_reset_req", mem_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
